// File: rtl/axi_master_read.sv
// rtl/axi_master_read.sv - single-outstanding AXI INCR read initiator for a core request port
module axi_master_read #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  input  logic [3:0]  core_len,
  input  logic [2:0]  core_size,
  output logic        core_busy,
  output logic [31:0] core_rdata,
  output logic        core_rvalid,
  output logic        core_done,
  output logic        core_error,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state;
  logic [3:0] len_q;
  logic [3:0] beat_cnt;
  logic       beat;
  logic       last_expected;
  logic       beat_err;

  assign beat          = (state == DATA) && RVALID && RREADY;
  assign last_expected = (beat_cnt == len_q);
  // RLAST must coincide exactly with the final expected beat; either mismatch is an error
  assign beat_err      = (RRESP != 2'b00) || (RID != MASTER_ID) || (RLAST != last_expected);
  assign core_busy     = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      len_q       <= 4'd0;
      beat_cnt    <= 4'd0;
      core_rdata  <= 32'd0;
      core_rvalid <= 1'b0;
      core_done   <= 1'b0;
      core_error  <= 1'b0;
      ARID        <= 4'd0;
      ARADDR      <= 32'd0;
      ARLEN       <= 4'd0;
      ARSIZE      <= 3'd0;
      ARBURST     <= 2'b00;
      ARVALID     <= 1'b0;
      RREADY      <= 1'b0;
    end else begin
      core_rvalid <= 1'b0;
      core_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req) begin
            ARID       <= MASTER_ID;
            ARADDR     <= core_addr;
            ARLEN      <= core_len;
            ARSIZE     <= core_size;
            ARBURST    <= 2'b01;
            ARVALID    <= 1'b1;
            len_q      <= core_len;
            beat_cnt   <= 4'd0;
            core_error <= 1'b0;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY) begin
            ARID    <= 4'd0;
            ARADDR  <= 32'd0;
            ARLEN   <= 4'd0;
            ARSIZE  <= 3'd0;
            ARBURST <= 2'b00;
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            core_rdata  <= RDATA;
            core_rvalid <= 1'b1;
            beat_cnt    <= beat_cnt + 4'd1;
            if (beat_err) core_error <= 1'b1;
            if (RLAST || last_expected) begin
              RREADY    <= 1'b0;
              core_done <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_read.sv
// tb/tb_axi_master_read.sv - directed scoreboard bench for axi_master_read
module tb_axi_master_read;
  localparam logic [3:0] MID = 4'd5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        core_req = 1'b0;
  logic [31:0] core_addr = 32'd0;
  logic [3:0]  core_len = 4'd0;
  logic [2:0]  core_size = 3'd0;
  logic        core_busy;
  logic [31:0] core_rdata;
  logic        core_rvalid;
  logic        core_done;
  logic        core_error;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [3:0]  RID = 4'd0;
  logic [31:0] RDATA = 32'd0;
  logic [1:0]  RRESP = 2'b00;
  logic        RLAST = 1'b0;
  logic        RVALID = 1'b0;
  logic        RREADY;

  axi_master_read #(.MASTER_ID(MID)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_addr(core_addr), .core_len(core_len), .core_size(core_size),
    .core_busy(core_busy), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .core_done(core_done), .core_error(core_error),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        done_q[$];
  int rv_count = 0;
  int done_count = 0;
  int done_cyc = 0;
  int acc_cyc = 0;
  int rv_start = 0;
  int exp_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard side: every delivered beat and every completion is matched against the queues
  always @(negedge clock) begin
    if (reset && core_rvalid) begin
      rv_count++;
      if (exp_q.size() == 0) chk("rvalid_without_expected_beat", 32'(exp_q.size()), 32'd1);
      else chk("rdata", core_rdata, exp_q.pop_front());
    end
    if (reset && core_done) begin
      done_count++;
      done_cyc = cyc;
      chk("done_with_final_rvalid", 32'(core_rvalid), 32'd1);
      chk("busy_low_at_done", 32'(core_busy), 32'd0);
      if (done_q.size() == 0) chk("done_without_expectation", 32'(done_q.size()), 32'd1);
      else chk("error_at_done", 32'(core_error), 32'(done_q.pop_front()));
    end
  end

  task automatic check_idle(input string t);
    chk({t, "_busy"}, 32'(core_busy), 32'd0);
    chk({t, "_rdata"}, core_rdata, 32'd0);
    chk({t, "_rvalid"}, 32'(core_rvalid), 32'd0);
    chk({t, "_done"}, 32'(core_done), 32'd0);
    chk({t, "_error"}, 32'(core_error), 32'd0);
    chk({t, "_arvalid"}, 32'(ARVALID), 32'd0);
    chk({t, "_araddr"}, ARADDR, 32'd0);
    chk({t, "_arlen_arsize_arburst_arid"}, 32'({ARLEN, ARSIZE, ARBURST, ARID}), 32'd0);
    chk({t, "_rready"}, 32'(RREADY), 32'd0);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s);
    @(negedge clock);
    core_req = 1'b1; core_addr = a; core_len = l; core_size = s;
    acc_cyc = cyc;
    rv_start = rv_count;
    @(negedge clock);
    core_req = 1'b0;
    chk("busy_after_accept", 32'(core_busy), 32'd1);
    chk("arvalid_after_accept", 32'(ARVALID), 32'd1);
    chk("error_cleared_on_accept", 32'(core_error), 32'd0);
  endtask

  task automatic ar_phase(input int stall, input logic [31:0] a, input logic [3:0] l, input logic [2:0] s);
    for (int i = 0; i < stall; i++) begin
      chk("arvalid_hold", 32'(ARVALID), 32'd1);
      chk("araddr_hold", ARADDR, a);
      chk("arlen_hold", 32'(ARLEN), 32'(l));
      chk("rready_before_ar", 32'(RREADY), 32'd0);
      @(negedge clock);
    end
    ARREADY = 1'b1;
    chk("araddr", ARADDR, a);
    chk("arlen", 32'(ARLEN), 32'(l));
    chk("arsize", 32'(ARSIZE), 32'(s));
    chk("arburst", 32'(ARBURST), 32'h1);
    chk("arid", 32'(ARID), 32'(MID));
    chk("arvalid", 32'(ARVALID), 32'd1);
    @(negedge clock);
    ARREADY = 1'b0;
    chk("arvalid_after_hs", 32'(ARVALID), 32'd0);
    chk("araddr_after_hs", ARADDR, 32'd0);
    chk("rready_in_data", 32'(RREADY), 32'd1);
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id,
                      input logic last, input int gap, input bit fin, input logic e);
    int wait_n;
    wait_n = 0;
    for (int i = 0; i < gap; i++) @(negedge clock);
    RVALID = 1'b1; RDATA = d; RRESP = resp; RID = id; RLAST = last;
    while (RREADY !== 1'b1 && wait_n < 20) begin
      @(negedge clock);
      wait_n++;
    end
    if (wait_n == 20) chk("rready_timeout", 32'(RREADY), 32'd1);
    else begin
      exp_q.push_back(d);
      if (fin) begin
        done_q.push_back(e);
        exp_done++;
      end
    end
    @(negedge clock);
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_idle("reset");
    reset = 1'b1;

    // single beat, minimum latency
    do_req(32'h0000_1004, 4'd0, 3'd2);
    ar_phase(0, 32'h0000_1004, 4'd0, 3'd2);
    beat(32'hDEAD_BEEF, 2'b00, MID, 1'b1, 0, 1'b1, 1'b0);
    @(negedge clock);
    chk("single_done_latency", 32'(done_cyc - acc_cyc), 32'd3);
    chk("single_rvalid_count", 32'(rv_count - rv_start), 32'd1);

    // AR backpressure, plus a core_req while busy that must be ignored
    do_req(32'h0000_2000, 4'd1, 3'd2);
    core_req = 1'b1; core_addr = 32'h0000_BAD0; core_len = 4'd7;
    chk("rready_before_ar", 32'(RREADY), 32'd0);
    @(negedge clock);
    core_req = 1'b0;
    ar_phase(4, 32'h0000_2000, 4'd1, 3'd2);
    beat(32'h0000_00A1, 2'b00, MID, 1'b0, 0, 1'b0, 1'b0);
    beat(32'h0000_00A2, 2'b00, MID, 1'b1, 0, 1'b1, 1'b0);
    @(negedge clock);
    chk("bp_rvalid_count", 32'(rv_count - rv_start), 32'd2);

    // 4-beat burst with RVALID pattern 1,0,1,1,0,1
    do_req(32'h0000_3000, 4'd3, 3'd2);
    ar_phase(0, 32'h0000_3000, 4'd3, 3'd2);
    beat(32'h11, 2'b00, MID, 1'b0, 0, 1'b0, 1'b0);
    beat(32'h22, 2'b00, MID, 1'b0, 1, 1'b0, 1'b0);
    beat(32'h33, 2'b00, MID, 1'b0, 0, 1'b0, 1'b0);
    beat(32'h44, 2'b00, MID, 1'b1, 1, 1'b1, 1'b0);
    @(negedge clock);
    chk("burst_rvalid_count", 32'(rv_count - rv_start), 32'd4);

    // SLVERR on second beat
    do_req(32'h0000_4000, 4'd1, 3'd2);
    ar_phase(0, 32'h0000_4000, 4'd1, 3'd2);
    beat(32'h55, 2'b00, MID, 1'b0, 0, 1'b0, 1'b0);
    beat(32'h66, 2'b10, MID, 1'b1, 0, 1'b1, 1'b1);
    @(negedge clock);
    chk("error_holds_after_done", 32'(core_error), 32'd1);
    chk("badresp_rvalid_count", 32'(rv_count - rv_start), 32'd2);

    // next accept clears error; final beat missing RLAST
    do_req(32'h0000_4800, 4'd0, 3'd2);
    ar_phase(0, 32'h0000_4800, 4'd0, 3'd2);
    beat(32'h77, 2'b00, MID, 1'b0, 0, 1'b1, 1'b1);
    @(negedge clock);
    chk("missing_last_busy", 32'(core_busy), 32'd0);

    // premature RLAST on beat 2 of 4
    do_req(32'h0000_5000, 4'd3, 3'd2);
    ar_phase(0, 32'h0000_5000, 4'd3, 3'd2);
    beat(32'h88, 2'b00, MID, 1'b0, 0, 1'b0, 1'b0);
    beat(32'h99, 2'b00, MID, 1'b1, 0, 1'b1, 1'b1);
    @(negedge clock);
    chk("premature_rready_low", 32'(RREADY), 32'd0);
    chk("premature_rvalid_count", 32'(rv_count - rv_start), 32'd2);

    // asynchronous reset while beat 2 of 4 is on the bus
    do_req(32'h0000_6000, 4'd3, 3'd2);
    ar_phase(0, 32'h0000_6000, 4'd3, 3'd2);
    beat(32'hAA, 2'b00, MID, 1'b0, 0, 1'b0, 1'b0);
    RVALID = 1'b1; RDATA = 32'hBB; RID = MID;
    #2 reset = 1'b0;
    #1 check_idle("mid_reset");
    RVALID = 1'b0;
    chk("pending_beats_at_reset", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    do_req(32'h0000_7000, 4'd0, 3'd2);
    ar_phase(0, 32'h0000_7000, 4'd0, 3'd2);
    beat(32'hCC, 2'b00, MID, 1'b1, 0, 1'b1, 1'b0);
    @(negedge clock);
    chk("post_reset_error", 32'(core_error), 32'd0);
    chk("post_reset_done_latency", 32'(done_cyc - acc_cyc), 32'd3);

    repeat (2) @(negedge clock);
    chk("done_count", 32'(done_count), 32'(exp_done));
    chk("leftover_beats", 32'(exp_q.size()), 32'd0);
    chk("leftover_dones", 32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_master_read.md
# axi_master_read

Read-side AXI initiator placed between a CPU/cache request port and the AXI interconnect. It converts one single-cycle core read request (address, beat count, size) into an AXI AR handshake, then collects the R beats. Each beat is handed to the core as a registered one-cycle data pulse, and completion is signalled with a status flag. It is the counterpart of the slave read-channel responder on the same bus: one outstanding transaction, INCR bursts only.

## Interface
- MASTER_ID, default 4'd0, value driven on ARID and expected on RID.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- core_req  in  1  request strobe, sampled only in IDLE.
- core_addr  in  32  byte start address.
- core_len  in  4  beats minus one (AXI ARLEN encoding).
- core_size  in  3  AXI ARSIZE encoding.
- core_busy  out  1  high whenever state != IDLE.
- core_rdata  out  32  last received beat data, registered.
- core_rvalid  out  1  one-cycle pulse per delivered beat.
- core_done  out  1  one-cycle pulse at transaction end.
- core_error  out  1  status qualified by core_done; holds until next accept.
- ARID out 4; ARADDR out 32; ARLEN out 4; ARSIZE out 3; ARBURST out 2; ARVALID out 1; ARREADY in 1.
- RID in 4; RDATA in 32; RRESP in 2; RLAST in 1; RVALID in 1; RREADY out 1.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - core_req=1 latches addr, len, size into registers, clears the error register and beat counter, and moves to ADDR.
  - core_req in any other state is ignored; the core must wait for core_busy=0.
- ADDR:
  - ARVALID=1. ARADDR/ARLEN/ARSIZE come from the latched registers; ARID=MASTER_ID; ARBURST=2'b01 (INCR).
  - All AR outputs stay stable until ARVALID&&ARREADY, which moves the FSM to DATA.
  - Outside ADDR: ARVALID=0 and all AR payload outputs are 0.
- DATA:
  - RREADY=1 in DATA only.
  - A beat is each cycle with RVALID&&RREADY. On a beat: core_rdata<=RDATA, core_rvalid<=1 for the next cycle, beat counter increments (4-bit).
  - A beat sets error on any of: RRESP != 2'b00, RID != MASTER_ID, or RLAST disagreeing with (counter == latched len). The beat data is still delivered.
  - Termination: a beat with RLAST=1, or a beat with counter == len. Either goes to IDLE, with core_done<=1 on the next cycle.
  - A premature RLAST therefore ends the transaction with error=1. A missing RLAST on the final expected beat also ends it, with error=1.
- Error register is sticky within a transaction and cleared on the next accept. core_error is a direct register output.
- Reset mid-transaction returns immediately to IDLE with all outputs at reset values. No AR/R cleanup is performed; the system resets the interconnect together with this block.
- Reset values: state IDLE, core_busy 0, core_rdata 0, core_rvalid 0, core_done 0, core_error 0, ARVALID 0, RREADY 0, all AR payload 0.

## Timing
- Accept cycle N (IDLE, core_req=1): ARVALID=1 and core_busy=1 from N+1.
- ARREADY already high at N+1: AR handshake at N+1, RREADY=1 from N+2.
- ARREADY low: ARVALID holds indefinitely, payload unchanged.
- Beat handshake at cycle M: core_rvalid/core_rdata valid at M+1.
- Last beat at cycle L:
  - core_done and the final core_rvalid both pulse at L+1.
  - core_busy=0 at L+1.
  - A new core_req is accepted at L+1 at the earliest.
- RVALID gaps (RVALID=0) stall counting without error. Back-to-back beats give one beat per cycle.
- Minimum single-beat transaction: accept N, AR N+1, R N+2, done N+3.

## Test plan
- Single beat: core_req addr 0x0000_1004, len 0, size 2; ARREADY=1 immediately; one R beat RDATA 0xDEADBEEF, RLAST=1, RRESP 0 -> ARADDR 0x1004, ARLEN 0, ARBURST 01; core_rvalid with 0xDEADBEEF and core_done at the same cycle; core_error=0; done 3 cycles after accept.
- AR backpressure: ARREADY held low 5 cycles -> ARVALID held high with ARADDR/ARLEN constant for all 5 cycles; RREADY=0 until the handshake.
- Burst len 3 (4 beats) with RVALID gaps (pattern 1,0,1,1,0,1), data 0x11..0x44, RLAST on the 4th beat -> exactly 4 core_rvalid pulses in order; core_done on the 4th; error=0.
- Bad response: 2-beat burst, second beat RRESP=2'b10 -> both beats delivered; core_done with core_error=1; next request clears core_error.
- Premature RLAST: len 3, RLAST on beat 2 -> transaction ends after 2 core_rvalid pulses; core_done with core_error=1; RREADY=0 afterwards.
- Reset mid-DATA: assert reset during beat 2 of 4 -> all outputs 0 immediately (asynchronous); after release, a new single-beat request completes normally with error=0.
